// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT       = 8'hE0;
   localparam logic [7:0] PS2_BRK       = 8'hF0;
   localparam int         PS2_FRAME_LEN = 11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } prefix_state_e;

   typedef logic [8:0] key_code_t;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deframer: synchronizers, clock glitch
// filter, bit counter with inactivity watchdog, start/parity/stop checking.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int BIT_TIMEOUT = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam int WD_W  = $clog2(BIT_TIMEOUT + 1);

   logic [1:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       dat_sync_q, dat_sync_d;
   logic             filt_q, filt_d;
   logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
   logic             filt_prev_q, filt_prev_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             start_q, start_d;
   logic             par_q, par_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             strobe;
   logic             data_bit;

   assign strobe   = filt_prev_q & ~filt_q;
   assign data_bit = dat_sync_q[1];

   always_comb begin
      clk_sync_d  = {clk_sync_q[0], ps2_clk};
      dat_sync_d  = {dat_sync_q[0], ps2_data};
      filt_d      = filt_q;
      filt_cnt_d  = '0;
      filt_prev_d = filt_q;
      // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
      if (clk_sync_q[1] != filt_q) begin
         if (filt_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q[1];
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      start_d      = start_q;
      par_d        = par_q;
      wd_d         = '0;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      rx_byte_d    = rx_byte_q;
      if (strobe) begin
         if (bit_cnt_q == 4'd0) begin
            start_d = data_bit;
         end else if (bit_cnt_q <= 4'd8) begin
            shift_d = {data_bit, shift_q[7:1]};
         end else if (bit_cnt_q == 4'd9) begin
            par_d = data_bit;
         end else if (!start_q && data_bit && odd_parity_ok(shift_q, par_q)) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift_q;
         end else begin
            frame_err_d = 1'b1;
         end
         bit_cnt_d = (bit_cnt_q == 4'(PS2_FRAME_LEN - 1)) ? 4'd0 : bit_cnt_q + 4'd1;
      end else if (bit_cnt_q != 4'd0) begin
         // A stalled partial frame is dropped silently so the next frame realigns.
         if (wd_q == WD_W'(BIT_TIMEOUT - 1)) begin
            bit_cnt_d = 4'd0;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q   <= 2'b11;
         dat_sync_q   <= 2'b11;
         filt_q       <= 1'b1;
         filt_cnt_q   <= '0;
         filt_prev_q  <= 1'b1;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 8'h00;
         start_q      <= 1'b0;
         par_q        <= 1'b0;
         wd_q         <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_byte_q    <= 8'h00;
      end else begin
         clk_sync_q   <= clk_sync_d;
         dat_sync_q   <= dat_sync_d;
         filt_q       <= filt_d;
         filt_cnt_q   <= filt_cnt_d;
         filt_prev_q  <= filt_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         start_q      <= start_d;
         par_q        <= par_d;
         wd_q         <= wd_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         rx_byte_q    <= rx_byte_d;
      end
   end

   assign byte_valid = byte_valid_q;
   assign rx_byte    = rx_byte_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix resolution and per-key held-state table.
// Optional PS2_REPEAT_FILTER_EN suppresses typematic repeats of held keys.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int BIT_TIMEOUT = 20000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [511:0] key_down,
   output logic [8:0]   last_change,
   output logic         key_valid,
   output logic         keydown,
   output logic         frame_err
);

   logic          byte_valid;
   logic [7:0]    rx_byte;
   logic          rx_err;
   prefix_state_e state_q, state_d;
   logic          ev_valid;
   logic          ev_break;
   key_code_t     ev_code;
   logic [511:0]  key_down_q, key_down_d;
   key_code_t     last_change_q, last_change_d;
   logic          key_valid_q, key_valid_d;
   logic          is_prefix;

   ps2_frame_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .BIT_TIMEOUT (BIT_TIMEOUT)
   ) u_frame_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (rx_err)
   );

   assign is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (rx_err) begin
         state_d = ST_IDLE;
      end else if (byte_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_byte == PS2_EXT)      state_d = ST_EXT;
               else if (rx_byte == PS2_BRK) state_d = ST_BRK;
            end
            ST_EXT: begin
               if (rx_byte == PS2_BRK)      state_d = ST_EXT_BRK;
               else if (rx_byte != PS2_EXT) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Break states take any byte as data, including E0/F0.
   always_comb begin
      ev_valid = 1'b0;
      ev_break = 1'b0;
      ev_code  = '0;
      if (byte_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               ev_valid = !is_prefix;
               ev_code  = {1'b0, rx_byte};
            end
            ST_EXT: begin
               ev_valid = !is_prefix;
               ev_code  = {1'b1, rx_byte};
            end
            ST_BRK: begin
               ev_valid = 1'b1;
               ev_break = 1'b1;
               ev_code  = {1'b0, rx_byte};
            end
            default: begin
               ev_valid = 1'b1;
               ev_break = 1'b1;
               ev_code  = {1'b1, rx_byte};
            end
         endcase
      end
   end

   always_comb begin
      key_down_d    = key_down_q;
      last_change_d = last_change_q;
      key_valid_d   = 1'b0;
      if (ev_valid) begin
         if (ev_break) begin
            key_down_d[ev_code] = 1'b0;
            last_change_d       = ev_code;
            key_valid_d         = 1'b1;
         end else begin
`ifdef PS2_REPEAT_FILTER_EN
            if (!key_down_q[ev_code]) begin
               key_down_d[ev_code] = 1'b1;
               last_change_d       = ev_code;
               key_valid_d         = 1'b1;
            end
`else
            key_down_d[ev_code] = 1'b1;
            last_change_d       = ev_code;
            key_valid_d         = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_down_q    <= '0;
         last_change_q <= '0;
         key_valid_q   <= 1'b0;
      end else begin
         key_down_q    <= key_down_d;
         last_change_q <= last_change_d;
         key_valid_q   <= key_valid_d;
      end
   end

   assign key_down    = key_down_q;
   assign last_change = last_change_q;
   assign key_valid   = key_valid_q;
   assign keydown     = |key_down_q;
   assign frame_err   = rx_err;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receive-only PS/2 keyboard front end: synchronizes and filters the raw PS/2 clock/data lines, deframes 11-bit scan-code frames, resolves E0 (extended) and F0 (break) prefixes, and maintains a per-key held-state vector. Sits directly upstream of the start-screen/level-select logic, supplying its `keydown`, `last_change` and `ready` (`key_valid`) inputs in the system clock domain.

## Interface
- `FILTER_LEN`, 8: consecutive identical samples required before a filtered `ps2_clk` level changes.
- `BIT_TIMEOUT`, 20000: system cycles with no falling `ps2_clk` edge before a partial frame is discarded (200 µs at 100 MHz).
- `clk`  input  1  system clock, 100 MHz.
- `rst`  input  1  asynchronous, active-low reset.
- `ps2_clk`  input  1  raw PS/2 clock, asynchronous.
- `ps2_data`  input  1  raw PS/2 data, asynchronous.
- `key_down`  output  512  held state per 9-bit code {ext, byte}.
- `last_change`  output  9  code of most recent make/break event.
- `key_valid`  output  1  one-cycle pulse: `last_change`/`key_down` just updated.
- `keydown`  output  1  OR-reduction of `key_down`.
- `frame_err`  output  1  one-cycle pulse on parity/start/stop error.

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass a 2-FF synchronizer; `ps2_clk` then a FILTER_LEN-sample glitch filter. A falling edge of filtered clock is a bit strobe; `ps2_data` (synchronized) sampled at that strobe.
- Frame: bit0 start (must be 0), bits1–8 data LSB-first, bit9 odd parity over data+parity, bit10 stop (must be 1). 4-bit bit counter 0..10; wraps to 0 after bit 10.
- Good frame: one-cycle internal `byte_valid` with 8-bit byte. Bad start/parity/stop: `frame_err` pulse, byte discarded, prefix FSM forced to IDLE.
- Watchdog: counter cleared on every bit strobe; reaching BIT_TIMEOUT with bit counter ≠ 0 clears bit counter, prefix FSM unchanged, no `frame_err`.
- Prefix FSM states IDLE, EXT, BRK, EXT_BRK, updated on `byte_valid` only:
  - IDLE: E0→EXT; F0→BRK; other b→make {0,b}, stay IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; other b→make {1,b}→IDLE.
  - BRK: b→break {0,b}→IDLE (E0/F0 here treated as data).
  - EXT_BRK: b→break {1,b}→IDLE.
- Make: `key_down[code]`←1, `last_change`←code, `key_valid` pulse. Break: `key_down[code]`←0, `last_change`←code, `key_valid` pulse. Break of a key not held still pulses.
- E1 (Pause) sequences unsupported; bytes decoded literally.
- Reset values: `key_down`=0, `last_change`=9'h000, `key_valid`=0, `keydown`=0, `frame_err`=0, FSM IDLE, counters 0. Reset mid-frame discards the partial frame.

## Timing
- Bit strobe: 2 sync + FILTER_LEN filter cycles + 1 edge-detect cycle after raw falling edge.
- `byte_valid` asserts the cycle after the stop-bit strobe; `frame_err` same cycle.
- `key_valid`, `last_change`, `key_down` update together one cycle after `byte_valid`; `keydown` is combinational from registered `key_down` (same cycle).
- Consecutive `key_valid` pulses ≥ one PS/2 frame apart; no backpressure, consumer samples on pulse.

## Configuration
- `PS2_REPEAT_FILTER_EN` defined: make code for a key whose `key_down` bit is already 1 (typematic repeat) updates nothing and produces no `key_valid`.
- Undefined: every make, including repeats, pulses `key_valid` and rewrites `last_change`.

## Structure
- Package `ps2_pkg`: `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, frame length 11, prefix-FSM state enum, 9-bit code type.
- Sub-module `ps2_frame_rx`: synchronizer, filter, bit counter, watchdog, parity check; outputs `byte_valid`, byte, `frame_err`. Top holds prefix FSM and key table.

## Test plan
- Frame 0x16 → `key_valid` pulse, `last_change`=9'h016, `key_down[22]`=1, `keydown`=1.
- Then F0,16 → one `key_valid` (on 16 only), `last_change`=9'h016, `key_down[22]`=0, `keydown`=0.
- E0,75 then E0,F0,75 → `last_change`=9'h175, `key_down[373]` set then cleared, two pulses total.
- 0x1E frame with flipped parity → `frame_err` pulse, no `key_valid`; following good 0x26 → `last_change`=9'h026.
- 5 bits then BIT_TIMEOUT idle cycles, then full 0x1E → decoded as 9'h01E, no `frame_err`; `rst` low mid-frame → all outputs zero.
- 0x16 sent three times: with `PS2_REPEAT_FILTER_EN` one `key_valid`; without, three.
